// File: rtl/aes_pkg.sv
// Shared AES constants: datapath widths, inverse S-box table, inverse SubBytes FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package aes_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_WORD_W  = 32;
   localparam int AES_NWORDS  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } inv_sub_state_t;

   // Inverse S-box, indexed by the substituted byte value.
   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/inv_sbox.sv
// Single-byte AES inverse S-box lookup from the shared package table.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module inv_sbox
   import aes_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);

   assign dout = INV_SBOX[din];

endmodule

// File: rtl/inv_sub_bytes_stage.sv
// Iterative inverse SubBytes: one 32-bit word per cycle through four byte lookups, MS word first.
// Latency: 4 cycles from input transfer to out_valid; one block per 5 cycles, overlapped in DONE.
// Backpressure: holds result stable in DONE while out_ready is low; in_ready follows out_ready there.
module inv_sub_bytes_stage
   import aes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [AES_STATE_W-1:0] in_state,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [AES_STATE_W-1:0] out_state,
   output logic                   out_valid,
   input  logic                   out_ready
);

   inv_sub_state_t        state_q;
   inv_sub_state_t        state_d;
   logic [AES_STATE_W-1:0] work;
   logic [1:0]             cnt;

   logic                   load_en;
   logic                   step_en;
   logic [AES_WORD_W-1:0]  sel_word;
   logic [AES_WORD_W-1:0]  sub_word;
   logic [AES_STATE_W-1:0] work_sub;

   assign out_state = work;

   // Word select: cnt 0 picks the most significant word, cnt 3 the least.
   always_comb begin
      sel_word = work[127:96];
      case (cnt)
         2'd0:    sel_word = work[127:96];
         2'd1:    sel_word = work[95:64];
         2'd2:    sel_word = work[63:32];
         default: sel_word = work[31:0];
      endcase
   end

   // Four independent byte lookups cover one word.
   for (genvar b = 0; b < 4; b++) begin : g_sbox
      inv_sbox u_inv_sbox (
         .din  (sel_word[b*8 +: 8]),
         .dout (sub_word[b*8 +: 8])
      );
   end

   // Write the substituted word back into its own slot, leave the others untouched.
   always_comb begin
      work_sub = work;
      case (cnt)
         2'd0:    work_sub[127:96] = sub_word;
         2'd1:    work_sub[95:64]  = sub_word;
         2'd2:    work_sub[63:32]  = sub_word;
         default: work_sub[31:0]   = sub_word;
      endcase
   end

   // Next-state and handshake decode; only in_ready in DONE looks at out_ready.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      load_en   = 1'b0;
      step_en   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load_en = 1'b1;
               state_d = SUB;
            end
         end
         SUB: begin
            step_en = 1'b1;
            if (cnt == 2'd3) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  load_en = 1'b1;
                  state_d = SUB;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset abandons any block in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Working register and word counter: load a fresh block or substitute one word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work <= '0;
         cnt  <= 2'd0;
      end else if (load_en) begin
         work <= in_state;
         cnt  <= 2'd0;
      end else if (step_en) begin
         work <= work_sub;
         cnt  <= cnt + 2'd1;
      end
   end

endmodule

// File: tb/tb_inv_sub_bytes_stage.sv
// Directed self-checking bench for inv_sub_bytes_stage.
// Latency: checks exact 4-edge latency and 5-cycle overlapped spacing.
// Backpressure: holds out_ready low in DONE and checks output stability.
module tb_inv_sub_bytes_stage;
   import aes_pkg::*;

   logic         clk;
   logic         rst;
   logic [127:0] in_state;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] out_state;
   logic         out_valid;
   logic         out_ready;

   int checks = 0;
   int errors = 0;

   inv_sub_bytes_stage dut (
      .clk       (clk),
      .rst       (rst),
      .in_state  (in_state),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_state (out_state),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // GF(2^8) multiply with the AES polynomial.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   // Forward S-box from first principles: field inverse then affine map.
   function automatic logic [7:0] sbox_fwd(input logic [7:0] v);
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int k = 1; k < 256; k++) begin
         if (gmul(v, 8'(k)) == 8'h01) inv = 8'(k);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return s;
   endfunction

   // Present one block and wait for the accepting edge (IDLE assumed).
   task automatic send(input logic [127:0] blk);
      in_state = blk;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_state = '0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || out_state !== 128'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: out_valid=%b in_ready=%b out_state=%h, want 0/1/0", out_valid, in_ready, out_state);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      // Reset two edges after accept, mid-substitution.
      send({4{32'h637CFF52}});
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_state !== 128'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_sub: out_valid=%b in_ready=%b out_state=%h, want 0/1/0", out_valid, in_ready, out_state);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_no_output cyc%0d: out_valid=%b in_ready=%b, want 0/1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_zero();
      out_ready = 1'b1;
      send(128'h0);
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (out_valid !== 1'b0 && i < 4) begin
            errors++;
            $display("FAIL zero_early_valid edge%0d: out_valid=%b want 0", i, out_valid);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (out_valid !== 1'b1 || out_state !== {16{8'h52}}) begin
         errors++;
         $display("FAIL zero_vector: out_valid=%b out_state=%h, want 1/%h", out_valid, out_state, {16{8'h52}});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mixed();
      out_ready = 1'b1;
      send({4{32'h637CFF52}});
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== (i == 4)) begin
            errors++;
            $display("FAIL mixed_latency edge%0d: out_valid=%b want %b", i, out_valid, (i == 4));
         end
      end
      checks++;
      if (out_state !== {4{32'h00017D48}}) begin
         errors++;
         $display("FAIL mixed_vector: out_state=%h want %h", out_state, {4{32'h00017D48}});
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mixed_return_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_exhaustive();
      logic [127:0] blk;
      logic [7:0]   x, y;
      int           waited;
      out_ready = 1'b1;
      for (int b = 0; b < 16; b++) begin
         for (int i = 0; i < 16; i++) blk[i*8 +: 8] = 8'(b * 16 + i);
         send(blk);
         waited = 0;
         while (out_valid !== 1'b1 && waited < 8) begin
            @(posedge clk); #1;
            waited++;
         end
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL exh_timeout blk%0d: out_valid=%b want 1", b, out_valid);
         end
         for (int i = 0; i < 16; i++) begin
            x = blk[i*8 +: 8];
            y = out_state[i*8 +: 8];
            checks++;
            if (y !== INV_SBOX[x]) begin
               errors++;
               $display("FAIL exh_table in=%h: got %h want %h", x, y, INV_SBOX[x]);
            end
            checks++;
            if (sbox_fwd(y) !== x) begin
               errors++;
               $display("FAIL exh_roundtrip in=%h: sbox(%h)=%h want %h", x, y, sbox_fwd(y), x);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      send({16{8'h7C}});
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
      end
      // Offer a competing block that must be ignored.
      in_valid = 1'b1;
      in_state = {16{8'hAA}};
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_state !== {16{8'h01}} || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc%0d: out_valid=%b in_ready=%b out_state=%h, want 1/0/%h",
                     i, out_valid, in_ready, out_state, {16{8'h01}});
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/1", in_ready, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_idle: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] blk [3];
      logic [127:0] exp [3];
      int idx, oidx, last;
      logic acc;
      blk[0] = 128'h0;               exp[0] = {16{8'h52}};
      blk[1] = {4{32'h637CFF52}};    exp[1] = {4{32'h00017D48}};
      blk[2] = {16{8'h09}};          exp[2] = {16{8'h40}};
      idx = 0; oidx = 0; last = 0;
      out_ready = 1'b1;
      in_state = blk[0];
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 25; cyc++) begin
         if (out_valid === 1'b1) begin
            checks++;
            if (oidx >= 3) begin
               errors++;
               $display("FAIL b2b_extra cyc%0d: unexpected block %h", cyc, out_state);
            end else begin
               if (out_state !== exp[oidx]) begin
                  errors++;
                  $display("FAIL b2b_data blk%0d: got %h want %h", oidx, out_state, exp[oidx]);
               end
               if (oidx > 0) begin
                  checks++;
                  if (cyc - last !== 5) begin
                     errors++;
                     $display("FAIL b2b_spacing blk%0d: got %0d cycles want 5", oidx, cyc - last);
                  end
               end
            end
            last = cyc;
            oidx++;
         end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 3) in_state = blk[idx];
            else in_valid = 1'b0;
         end
      end
      checks++;
      if (oidx !== 3 || idx !== 3) begin
         errors++;
         $display("FAIL b2b_count: outputs=%0d inputs=%0d want 3/3", oidx, idx);
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_mixed();
      test_exhaustive();
      test_backpressure();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
